// File: rtl/load_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_unit_pkg
// Shared encodings for the data-memory block: load types consumed by the load
// unit, store types consumed by datamem, and the memory-mapped hardware counter
// address. Also provides a helper that recognises a real load request.
// -----------------------------------------------------------------------------
package load_unit_pkg;

    // Load type encodings (3-bit info_load field)
    localparam logic [2:0] Lb    = 3'b000;
    localparam logic [2:0] Lh    = 3'b001;
    localparam logic [2:0] Lw    = 3'b010;
    localparam logic [2:0] Lbu   = 3'b100;
    localparam logic [2:0] Lhu   = 3'b101;
    localparam logic [2:0] LNONE = 3'b111;

    // Store type encodings used by datamem
    localparam logic [1:0] Sb = 2'b00;
    localparam logic [1:0] Sh = 2'b01;
    localparam logic [1:0] Sw = 2'b10;

    // Byte address of the memory-mapped hardware counter
    localparam logic [31:0] HARDWARE_COUNTER_ADDR = 32'hFFFF_FFF0;

    // True only for the five defined load codes; every other code behaves as LNONE.
    function automatic logic is_load(input logic [2:0] code);
        return (code == Lb) || (code == Lh) || (code == Lw) ||
               (code == Lbu) || (code == Lhu);
    endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational byte/half/word selection and sign/zero extension of a
// little-endian 32-bit memory word.
//   addr_data   in  32  word read at the word address
//   addr_rem    in   2  byte offset within the word
//   info_load   in   3  load type (load_unit_pkg encodings)
//   ext_data    out 32  aligned, extended value
//   misaligned  out  1  access is illegal for its alignment
// -----------------------------------------------------------------------------
module load_extract
    import load_unit_pkg::*;
(
    input  logic [31:0] addr_data,
    input  logic [1:0]  addr_rem,
    input  logic [2:0]  info_load,
    output logic [31:0] ext_data,
    output logic        misaligned
);

    // Split the word into its little-endian byte lanes.
    logic [7:0] lane [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = addr_data[8*gi +: 8];
        end
    endgenerate

    logic [1:0]  rem_plus1;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // rem_plus1 wraps at rem=3; that case is rejected as misaligned for halves.
    assign rem_plus1 = addr_rem + 2'd1;
    assign byte_sel  = lane[addr_rem];
    assign half_sel  = {lane[rem_plus1], lane[addr_rem]};

    always_comb begin
        ext_data   = 32'h0;
        misaligned = 1'b0;
        case (info_load)
            Lb:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            Lbu: ext_data = {24'h0, byte_sel};
            Lh: begin
                if (addr_rem == 2'd3) misaligned = 1'b1;
                else                  ext_data   = {{16{half_sel[15]}}, half_sel};
            end
            Lhu: begin
                if (addr_rem == 2'd3) misaligned = 1'b1;
                else                  ext_data   = {16'h0, half_sel};
            end
            Lw: begin
                // Word is returned whole even when flagged.
                ext_data   = addr_data;
                misaligned = (addr_rem != 2'd0);
            end
            default: begin
                ext_data   = 32'h0;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
// Load-data alignment/extension stage between the data-memory read and the
// writeback register. One cycle of latency, captures every cycle.
//   clk         in   1  system clock
//   rst         in   1  synchronous active-high reset
//   addr_data   in  32  memory word at the word address
//   addr_rem    in   2  byte offset within the word
//   alu_result  in  32  effective byte address; low two bits cross-checked
//   info_load   in   3  load type
//   data        out 32  registered load result
//   misaligned  out  1  registered illegal-alignment flag
// -----------------------------------------------------------------------------
module load_unit
    import load_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_data,
    input  logic [1:0]  addr_rem,
    input  logic [31:0] alu_result,
    input  logic [2:0]  info_load,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [31:0] data_d, data_q;
    logic        mis_d, mis_q;
    logic        extract_mis;
    logic        addr_mismatch;

    // Only the byte offset of the effective address matters here.
    logic unused_alu_hi;
    assign unused_alu_hi = ^alu_result[31:2];

    load_extract u_extract (
        .addr_data  (addr_data),
        .addr_rem   (addr_rem),
        .info_load  (info_load),
        .ext_data   (data_d),
        .misaligned (extract_mis)
    );

    // A disagreement between the ALU address and the offset used to fetch
    // indicates a pipeline inconsistency; flag it but keep the computed data.
    assign addr_mismatch = is_load(info_load) && (alu_result[1:0] != addr_rem);
    assign mis_d         = extract_mis | addr_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 32'h0;
            mis_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            mis_q  <= mis_d;
        end
    end

    assign data       = data_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_load_unit.sv
// -----------------------------------------------------------------------------
// tb_load_unit
// Directed self-checking bench for load_unit. Each step drives one access,
// waits for the capturing edge and compares the registered outputs against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_load_unit;

    logic        clk;
    logic        rst;
    logic [31:0] addr_data;
    logic [1:0]  addr_rem;
    logic [31:0] alu_result;
    logic [2:0]  info_load;
    logic [31:0] data;
    logic        misaligned;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [31:0] W = 32'h80FF7F01;

    load_unit dut (
        .clk        (clk),
        .rst        (rst),
        .addr_data  (addr_data),
        .addr_rem   (addr_rem),
        .alu_result (alu_result),
        .info_load  (info_load),
        .data       (data),
        .misaligned (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access, let it be captured, then check both outputs.
    task automatic step(input logic r, input logic [2:0] t, input logic [1:0] rem,
                        input logic [31:0] alu, input logic [31:0] word,
                        input logic [31:0] exp_d, input logic exp_m, input string tag);
        rst        = r;
        info_load  = t;
        addr_rem   = rem;
        alu_result = alu;
        addr_data  = word;
        @(posedge clk);
        #1;
        tests_run++;
        assert (data === exp_d) else begin
            tests_failed++;
            $error("FAIL %s data: got %08h expected %08h", tag, data, exp_d);
        end
        tests_run++;
        assert (misaligned === exp_m) else begin
            tests_failed++;
            $error("FAIL %s misaligned: got %0b expected %0b", tag, misaligned, exp_m);
        end
        $display("[TB] %-14s type=%03b rem=%0d alu=%08h word=%08h -> data=%08h mis=%0b",
                 tag, t, rem, alu, word, data, misaligned);
    endtask

    initial begin
        rst = 1'b1; info_load = 3'b010; addr_rem = 2'd1;
        alu_result = 32'h0; addr_data = 32'hDEADBEEF;

        // Reset with a misaligned word load pending
        step(1'b1, 3'b010, 2'd1, 32'h0000_1003, 32'hDEADBEEF, 32'h0, 1'b0, "reset");
        // First load after release
        step(1'b0, 3'b000, 2'd0, 32'h0000_1000, W, 32'h00000001, 1'b0, "lb_r0");

        // Byte loads
        step(1'b0, 3'b000, 2'd1, 32'h0000_1001, W, 32'h0000007F, 1'b0, "lb_r1");
        step(1'b0, 3'b000, 2'd2, 32'h0000_1002, W, 32'hFFFFFFFF, 1'b0, "lb_r2");
        step(1'b0, 3'b000, 2'd3, 32'h0000_1003, W, 32'hFFFFFF80, 1'b0, "lb_r3");
        step(1'b0, 3'b100, 2'd3, 32'h0000_1003, W, 32'h00000080, 1'b0, "lbu_r3");
        step(1'b0, 3'b100, 2'd2, 32'h0000_1002, W, 32'h000000FF, 1'b0, "lbu_r2");

        // Half loads
        step(1'b0, 3'b001, 2'd0, 32'h0000_1000, W, 32'h00007F01, 1'b0, "lh_r0");
        step(1'b0, 3'b001, 2'd1, 32'h0000_1001, W, 32'hFFFFFF7F, 1'b0, "lh_r1");
        step(1'b0, 3'b001, 2'd2, 32'h0000_1002, W, 32'hFFFF80FF, 1'b0, "lh_r2");
        step(1'b0, 3'b101, 2'd2, 32'h0000_1002, W, 32'h000080FF, 1'b0, "lhu_r2");
        step(1'b0, 3'b101, 2'd1, 32'h0000_1001, W, 32'h0000FF7F, 1'b0, "lhu_r1");
        step(1'b0, 3'b001, 2'd3, 32'h0000_1003, W, 32'h00000000, 1'b1, "lh_r3");
        step(1'b0, 3'b101, 2'd3, 32'h0000_1003, W, 32'h00000000, 1'b1, "lhu_r3");

        // Word loads and no-load codes
        step(1'b0, 3'b010, 2'd0, 32'h0000_1000, W, 32'h80FF7F01, 1'b0, "lw_r0");
        step(1'b0, 3'b010, 2'd2, 32'h0000_1002, W, 32'h80FF7F01, 1'b1, "lw_r2");
        step(1'b0, 3'b111, 2'd1, 32'h0000_1001, W, 32'h00000000, 1'b0, "lnone");
        step(1'b0, 3'b011, 2'd0, 32'h0000_1000, W, 32'h00000000, 1'b0, "code011");
        step(1'b0, 3'b110, 2'd2, 32'h0000_1002, W, 32'h00000000, 1'b0, "code110");

        // Address consistency check
        step(1'b0, 3'b100, 2'd1, 32'h0000_1002, W, 32'h0000007F, 1'b1, "mismatch_lbu");
        step(1'b0, 3'b010, 2'd0, 32'h0000_1001, W, 32'h80FF7F01, 1'b1, "mismatch_lw");
        step(1'b0, 3'b111, 2'd0, 32'h0000_1003, W, 32'h00000000, 1'b0, "mismatch_none");

        // Streaming with reset asserted on the middle load
        step(1'b0, 3'b000, 2'd1, 32'h0000_2001, W, 32'h0000007F, 1'b0, "stream_lb");
        step(1'b1, 3'b101, 2'd0, 32'h0000_2000, W, 32'h00000000, 1'b0, "stream_rst");
        step(1'b0, 3'b010, 2'd0, 32'h0000_2000, W, 32'h80FF7F01, 1'b0, "stream_lw");
        step(1'b0, 3'b101, 2'd0, 32'h0000_2000, W, 32'h00007F01, 1'b0, "stream_lhu");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
